// File: rtl/press_repeat.sv
// Push-button front end: synchronise and debounce a raw switch, then emit an
// increment strobe on press followed by auto-repeat strobes while held.
module press_repeat #(
    parameter int unsigned DEBOUNCE_CYCLES = 250000,
    parameter int unsigned HOLD_CYCLES     = 12500000,
    parameter int unsigned REPEAT_CYCLES   = 2500000
) (
    input  logic clock,
    input  logic reset_n,
    input  logic i_Switch,
    output logic o_Switch,
    output logic o_pulse,
    output logic o_held
);

    localparam int unsigned DW = $clog2(DEBOUNCE_CYCLES);
    localparam int unsigned HW = $clog2(HOLD_CYCLES);
    localparam int unsigned RW = $clog2(REPEAT_CYCLES);

    localparam logic [DW-1:0] DEB_LAST  = DW'(DEBOUNCE_CYCLES - 1);
    localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYCLES - 1);
    localparam logic [RW-1:0] REP_LAST  = RW'(REPEAT_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE,
        PRESSED,
        REPEAT
    } state_t;

    state_t          state, state_next;
    logic            sync1, s;
    logic [DW-1:0]   deb_cnt, deb_cnt_next;
    logic [HW-1:0]   hold_cnt, hold_cnt_next;
    logic [RW-1:0]   rep_cnt, rep_cnt_next;
    logic            sw_next;
    logic            rise, fall;
    logic            pulse_next;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            sync1    <= 1'b0;
            s        <= 1'b0;
            deb_cnt  <= '0;
            o_Switch <= 1'b0;
            state    <= IDLE;
            hold_cnt <= '0;
            rep_cnt  <= '0;
            o_pulse  <= 1'b0;
            o_held   <= 1'b0;
        end else begin
            sync1    <= i_Switch;
            s        <= sync1;
            deb_cnt  <= deb_cnt_next;
            o_Switch <= sw_next;
            state    <= state_next;
            hold_cnt <= hold_cnt_next;
            rep_cnt  <= rep_cnt_next;
            o_pulse  <= pulse_next;
            o_held   <= (state_next == REPEAT);
        end
    end

    // Debounced level is computed one step ahead so the FSM can react on the
    // same edge that o_Switch changes.
    always_comb begin
        deb_cnt_next = '0;
        sw_next      = o_Switch;
        if (s != o_Switch) begin
            if (deb_cnt == DEB_LAST) begin
                sw_next = s;
            end else begin
                deb_cnt_next = deb_cnt + 1'b1;
            end
        end
    end

    assign rise = sw_next & ~o_Switch;
    assign fall = ~sw_next & o_Switch;

    // Release is tested first so a coincident terminal count yields no pulse.
    always_comb begin
        state_next    = state;
        hold_cnt_next = '0;
        rep_cnt_next  = '0;
        pulse_next    = 1'b0;
        case (state)
            IDLE: begin
                if (rise) begin
                    state_next = PRESSED;
                    pulse_next = 1'b1;
                end
            end
            PRESSED: begin
                if (fall) begin
                    state_next = IDLE;
                end else if (hold_cnt == HOLD_LAST) begin
                    state_next = REPEAT;
                    pulse_next = 1'b1;
                end else begin
                    hold_cnt_next = hold_cnt + 1'b1;
                end
            end
            REPEAT: begin
                if (fall) begin
                    state_next = IDLE;
                end else if (rep_cnt == REP_LAST) begin
                    pulse_next = 1'b1;
                end else begin
                    rep_cnt_next = rep_cnt + 1'b1;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_press_repeat.sv
// Vector-table bench for press_repeat with small parameters; expected outputs
// per edge are derived from the press/hold/repeat edge numbers.
module tb_press_repeat;

    logic clock;
    logic reset_n;
    logic i_Switch;
    logic o_Switch;
    logic o_pulse;
    logic o_held;

    press_repeat #(
        .DEBOUNCE_CYCLES(4),
        .HOLD_CYCLES(10),
        .REPEAT_CYCLES(3)
    ) dut (
        .clock(clock),
        .reset_n(reset_n),
        .i_Switch(i_Switch),
        .o_Switch(o_Switch),
        .o_pulse(o_pulse),
        .o_held(o_held)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        bit rst_n;
        bit sw;
        bit e_osw;
        bit e_pulse;
        bit e_held;
    } vec_t;

    typedef struct {
        string tag;
        int    idx;
        bit    osw;
        bit    pulse;
        bit    held;
    } exp_t;

    vec_t vecs[$];
    exp_t sb[$];
    int   n_vec = 0;
    int   n_err = 0;
    logic [0:11] bounce_pat;
    logic [0:11] glitch_pat;

    task automatic add(input bit r, input bit sw, input bit osw, input bit p, input bit h);
        vec_t v;
        v = '{r, sw, osw, p, h};
        vecs.push_back(v);
    endtask

    task automatic add_reset();
        add(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        add(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic check(input exp_t e);
        n_vec++;
        if (o_Switch !== e.osw || o_pulse !== e.pulse || o_held !== e.held) begin
            n_err++;
            $display("FAIL %s[%0d]: {o_Switch,o_pulse,o_held} got %b%b%b, expected %b%b%b",
                     e.tag, e.idx, o_Switch, o_pulse, o_held, e.osw, e.pulse, e.held);
        end
    endtask

    task automatic run(input string tag);
        exp_t e;
        for (int i = 0; i < vecs.size(); i++) begin
            reset_n  = vecs[i].rst_n;
            i_Switch = vecs[i].sw;
            e = '{tag, i, vecs[i].e_osw, vecs[i].e_pulse, vecs[i].e_held};
            sb.push_back(e);
            @(posedge clock);
            #1;
            check(sb.pop_front());
        end
        vecs.delete();
    endtask

    initial begin
        exp_t e;
        reset_n    = 1'b0;
        i_Switch   = 1'b0;
        bounce_pat = 12'b1110_1111_1111;
        glitch_pat = 12'b1110_0000_0000;

        // Clean press held 8 edges, then release.
        add_reset();
        for (int k = 1; k <= 8; k++) add(1'b1, 1'b1, k >= 6, k == 6, 1'b0);
        for (int k = 1; k <= 8; k++) add(1'b1, 1'b0, k <= 5, 1'b0, 1'b0);
        run("clean");

        // High for DEBOUNCE_CYCLES-1 cycles only: must be rejected.
        add_reset();
        for (int k = 1; k <= 12; k++) add(1'b1, glitch_pat[k-1], 1'b0, 1'b0, 1'b0);
        run("glitch");

        // Bounce: last rise lands before edge 5, so the level changes at edge 10.
        add_reset();
        for (int k = 1; k <= 12; k++) add(1'b1, bounce_pat[k-1], k >= 10, k == 10, 1'b0);
        for (int k = 1; k <= 8; k++) add(1'b1, 1'b0, k <= 5, 1'b0, 1'b0);
        run("bounce");

        // Long hold, then release so o_Switch falls on the repeat terminal edge 46.
        add_reset();
        for (int k = 1; k <= 40; k++)
            add(1'b1, 1'b1, k >= 6, k == 6 || (k >= 16 && (k - 16) % 3 == 0), k >= 16);
        for (int k = 41; k <= 52; k++)
            add(1'b1, 1'b0, k < 46, k == 43, k < 46);
        run("hold");

        // Into REPEAT, then asynchronous reset between clock edges.
        add_reset();
        for (int k = 1; k <= 20; k++)
            add(1'b1, 1'b1, k >= 6, k == 6 || k == 16 || k == 19, k >= 16);
        run("prehold");
        #2;
        reset_n = 1'b0;
        e = '{"async_reset", 0, 1'b0, 1'b0, 1'b0};
        sb.push_back(e);
        #1;
        check(sb.pop_front());

        add(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        add(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        for (int k = 1; k <= 10; k++) add(1'b1, 1'b1, k >= 6, k == 6, 1'b0);
        run("after_reset");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
